mano_exec_core: RTL
===================

MANO_EXEC_CORE -- requirements
Module: mano_exec_core

Interface
REQ-001 SHALL have parameter WORD_W, default 16, data/AC/DR/IR width; legal only when WORD_W >= ADDR_W+4.
REQ-002 SHALL have parameter ADDR_W, default 12, address/PC/AR width; memory depth is 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin execution at start_pc; sampled in IDLE or HALT only.
REQ-006 SHALL have port start_pc  input  ADDR_W  initial PC.
REQ-007 SHALL have port ld_en  input  1  preload write strobe.
REQ-008 SHALL have port ld_addr  input  ADDR_W  preload address.
REQ-009 SHALL have port ld_data  input  WORD_W  preload data.
REQ-010 SHALL have outputs pc_out (ADDR_W), ar_out (ADDR_W), ir_out (WORD_W), dr_out (WORD_W), ac_out (WORD_W), e_out (1); all registered.
REQ-011 SHALL have outputs busy (1, high outside IDLE/HALT) and halted (1, high in HALT).

Function
REQ-012 SHALL hold internal memory of 2**ADDR_W x WORD_W; synchronous write, combinational read.
REQ-013 SHALL decode IR as follows: I = IR[WORD_W-1], opcode = IR[WORD_W-2:WORD_W-4], address = IR[ADDR_W-1:0].
REQ-014 SHALL use FSM states IDLE, FETCH0, FETCH1, DECODE, INDIRECT, EXEC0, EXEC1, EXEC2, HALT.
REQ-015 SHALL, on start in IDLE/HALT: PC<=start_pc and go to FETCH0; otherwise remain in place.
REQ-016 SHALL execute FETCH0 as AR<=PC; FETCH1 as IR<=M[AR], PC<=PC+1.
REQ-017 SHALL handle DECODE as: opcode 111 -> HALT; else AR<=IR address; go to INDIRECT if I=1 (see REQ-031), else EXEC0.
REQ-018 SHALL handle INDIRECT as AR<=M[AR][ADDR_W-1:0], then go to EXEC0.
REQ-019 SHALL execute AND (000): EXEC0 DR<=M[AR]; EXEC1 AC<=AC & DR (bitwise); 2 exec cycles.
REQ-020 SHALL execute ADD (001): EXEC0 DR<=M[AR]; EXEC1 {E,AC}<=AC+DR at WORD_W+1 bits.
REQ-021 SHALL execute LDA (010): EXEC0 DR<=M[AR]; EXEC1 AC<=DR.
REQ-022 SHALL execute STA (011): EXEC0 M[AR]<=AC.
REQ-023 SHALL execute BUN (100): EXEC0 PC<=AR.
REQ-024 SHALL execute BSA (101): EXEC0 M[AR]<=PC zero-extended, AR<=AR+1; EXEC1 PC<=AR.
REQ-025 SHALL execute ISZ (110): EXEC0 DR<=M[AR]; EXEC1 DR<=DR+1; EXEC2 M[AR]<=DR, and PC<=PC+1 if DR==0.
REQ-026 SHALL return to FETCH0 after the final exec cycle of each instruction.
REQ-027 SHALL wrap PC and AR increments modulo 2**ADDR_W and DR increment modulo 2**WORD_W; E is changed only by ADD.
REQ-028 SHALL write ld_data to M[ld_addr] on ld_en only while busy=0; ld_en while busy=1 is ignored.
REQ-029 SHALL, on ld_en and start in the same cycle, perform both actions; the first fetch sees the loaded word.

Reset
REQ-030 SHALL, on reset low, asynchronously force state IDLE, with PC, AR, IR, DR, AC, E, busy and halted all 0; memory contents are not cleared; reset mid-instruction abandons it with no further memory writes.

Configuration
REQ-031 SHALL honour I=1 (INDIRECT state) when MANO_INDIRECT_EN is defined; without it, I is ignored, INDIRECT is unreachable, and all addressing is direct.

Verification
REQ-032 SHALL pass this test: preload M[0]=0x2010 (LDA 0x010), M[1]=0x1011 (ADD 0x011), M[2]=0x3012 (STA 0x012), M[3]=0x7000; M[0x10]=5, M[0x11]=7; start_pc=0 -> M[0x12]=12, AC=12, E=0, halted=1, PC=4.
REQ-033 SHALL pass this test: ADD with AC=0xFFFF, DR=0x0001 -> AC=0x0000, E=1.
REQ-034 SHALL pass this test: ISZ on M[0x20]=0xFFFF at PC=5 -> M[0x20]=0x0000, next fetch address 7; with M[0x20]=3 -> M[0x20]=4, next fetch address 6.
REQ-035 SHALL pass this test: BSA 0x030 at address 0x00A -> M[0x030]=0x000B, PC=0x031; BUN at address 0xFFF wraps so fetch follows from 0x000.
REQ-036 SHALL pass this test: with MANO_INDIRECT_EN defined, LDA I 0x040 (0xA040) with M[0x040]=0x050 and M[0x050]=0x1234 -> AC=0x1234; without the macro -> AC=0x0050.
REQ-037 SHALL pass this test: reset asserted during EXEC0 of STA -> memory is unchanged, all outputs are 0, state is IDLE; ld_en while busy leaves the target word unchanged.

Source files
------------

// File: rtl/mano_exec_core.sv
// mano_exec_core: multi-cycle Mano basic-computer execution core with internal memory.
// Optional feature: define MANO_INDIRECT_EN to honour the I bit (indirect addressing).
module mano_exec_core #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] ar_out,
    output logic [WORD_W-1:0] ir_out,
    output logic [WORD_W-1:0] dr_out,
    output logic [WORD_W-1:0] ac_out,
    output logic              e_out,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned SUM_W = WORD_W + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_BSA = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_DECODE, S_INDIRECT,
        S_EXEC0, S_EXEC1, S_EXEC2, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [WORD_W-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
    logic              e_q, e_d;
    logic              busy_q, halted_q;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] mem_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              use_ind;

    // Instruction field decode and combinational memory read at AR
    assign opcode  = ir_q[WORD_W-2 -: 3];
    assign ir_addr = ir_q[ADDR_W-1:0];
    assign mem_rd  = mem[ar_q];
`ifdef MANO_INDIRECT_EN
    assign use_ind = ir_q[WORD_W-1];
`else
    assign use_ind = 1'b0;
`endif

    // Next-state, register-transfer and memory-write decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ar_d      = ar_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        ac_d      = ac_q;
        e_d       = e_q;
        mem_we    = 1'b0;
        mem_waddr = ar_q;
        mem_wdata = ac_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = S_FETCH0;
                end
            end
            S_FETCH0: begin
                ar_d    = pc_q;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                ir_d    = mem_rd;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    ar_d    = ir_addr;
                    state_d = use_ind ? S_INDIRECT : S_EXEC0;
                end
            end
            S_INDIRECT: begin
                ar_d    = mem_rd[ADDR_W-1:0];
                state_d = S_EXEC0;
            end
            S_EXEC0: begin
                state_d = S_FETCH0;
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        dr_d    = mem_rd;
                        state_d = S_EXEC1;
                    end
                    OP_STA: begin
                        mem_we    = 1'b1;
                        mem_wdata = ac_q;
                    end
                    OP_BUN: pc_d = ar_q;
                    OP_BSA: begin
                        mem_we    = 1'b1;
                        mem_wdata = WORD_W'(pc_q);
                        ar_d      = ar_q + ADDR_W'(1);
                        state_d   = S_EXEC1;
                    end
                    default: ;
                endcase
            end
            S_EXEC1: begin
                state_d = S_FETCH0;
                case (opcode)
                    OP_AND: ac_d = ac_q & dr_q;
                    OP_ADD: {e_d, ac_d} = SUM_W'(ac_q) + SUM_W'(dr_q);
                    OP_LDA: ac_d = dr_q;
                    OP_BSA: pc_d = ar_q;
                    OP_ISZ: begin
                        dr_d    = dr_q + WORD_W'(1);
                        state_d = S_EXEC2;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                mem_we    = 1'b1;
                mem_wdata = dr_q;
                if (dr_q == '0) pc_d = pc_q + ADDR_W'(1);
                state_d   = S_FETCH0;
            end
            default: state_d = S_IDLE;
        endcase
        // Preload port only owns memory while the core is not executing
        if (ld_en && !busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
        end
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ar_q     <= '0;
            ir_q     <= '0;
            dr_q     <= '0;
            ac_q     <= '0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            ac_q     <= ac_d;
            e_q      <= e_d;
            busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted_q <= (state_d == S_HALT);
        end
    end

    // Memory array: synchronous write, never cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign pc_out = pc_q;
    assign ar_out = ar_q;
    assign ir_out = ir_q;
    assign dr_out = dr_q;
    assign ac_out = ac_q;
    assign e_out  = e_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule
